// File: rtl/fsk_word_deframer.sv
// Serial-to-parallel deframer for the FSK receive path: hunts for a sync byte, then emits
// WORDS 9-bit words with an even-parity verdict; abandons the frame if bits stall too long.
module fsk_word_deframer #(
    parameter logic [7:0] SYNC    = 8'b01111110,
    parameter int         WORDS   = 4,
    parameter int         TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [8:0] dataout,
    output logic       word_valid,
    output logic       parity_err,
    output logic       sync_lock,
    output logic       frame_err
);

    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t     state;
    logic [7:0] sh;
    logic [7:0] wreg;
    logic [3:0] bit_cnt;
    logic [3:0] word_cnt;
    logic [7:0] tcnt;

    logic [7:0] sh_next;
    logic [8:0] word_next;

    assign sh_next   = {sh[6:0], bit_in};
    assign word_next = {wreg, bit_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            sh         <= 8'h00;
            wreg       <= 8'h00;
            bit_cnt    <= 4'd0;
            word_cnt   <= 4'd0;
            tcnt       <= 8'd0;
            dataout    <= 9'h000;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            sync_lock  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                HUNT: begin
                    tcnt <= 8'd0;
                    if (bit_valid) begin
                        sh <= sh_next;
                        if (sh_next == SYNC) begin
                            state     <= PAYLOAD;
                            sync_lock <= 1'b1;
                            bit_cnt   <= 4'd0;
                            word_cnt  <= 4'd0;
                        end
                    end
                end
                PAYLOAD: begin
                    // An arriving bit always wins over an expiring timeout.
                    if (bit_valid) begin
                        tcnt <= 8'd0;
                        wreg <= word_next[7:0];
                        if (bit_cnt == 4'd8) begin
                            dataout    <= word_next;
                            parity_err <= ^word_next;
                            word_valid <= 1'b1;
                            bit_cnt    <= 4'd0;
                            if (word_cnt == 4'(WORDS - 1)) begin
                                // Clearing sh forces a fresh full sync for the next frame.
                                state     <= HUNT;
                                sync_lock <= 1'b0;
                                sh        <= 8'h00;
                                word_cnt  <= 4'd0;
                            end else begin
                                word_cnt <= word_cnt + 4'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (tcnt == 8'(TIMEOUT - 1)) begin
                        state     <= HUNT;
                        sync_lock <= 1'b0;
                        sh        <= 8'h00;
                        frame_err <= 1'b1;
                        tcnt      <= 8'd0;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule
